// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with an in-order prefetch ring between the PC/redirect logic and an
// instruction memory port; stale responses after a redirect are counted off and discarded.
module ifu_prefetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned       STEP     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcsel_i,
    input  logic [ADDR_W-1:0] dnpc_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              rsp_valid_i,
    input  logic [INST_W-1:0] rsp_data_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc_q;
    logic [PW-1:0]     alloc_q, fill_q, head_q;
    // pend_q: allocated entries still waiting for their response
    logic [CW-1:0]     count_q, pend_q, drop_q;
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;

    logic              req_fire, inst_fire, rsp_keep, rsp_drop;
    logic [CW:0]       inflight;

    assign inflight     = {1'b0, count_q} + {1'b0, drop_q};
    assign req_valid_o  = !rst && !pcsel_i && (inflight < (CW+1)'(DEPTH));
    assign req_addr_o   = fetch_pc_q;
    assign req_fire     = req_valid_o && req_ready_i;

    assign inst_valid_o = (count_q != '0) && filled_q[head_q];
    assign inst_o       = inst_q[head_q];
    assign pc_o         = pc_q[head_q];
    assign inst_fire    = inst_valid_o && inst_ready_i;

    assign rsp_drop     = rsp_valid_i && (drop_q != '0);
    assign rsp_keep     = rsp_valid_i && (drop_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
        end else if (pcsel_i) begin
            fetch_pc_q <= dnpc_i;
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            // A response arriving now is always discarded, so it retires one outstanding fetch.
            drop_q     <= drop_q + pend_q - CW'(rsp_valid_i);
        end else begin
            if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + ADDR_W'(STEP);
                alloc_q    <= alloc_q + PW'(1);
            end
            if (rsp_keep) begin
                fill_q <= fill_q + PW'(1);
            end
            if (inst_fire) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(req_fire) - CW'(inst_fire);
            pend_q  <= pend_q + CW'(req_fire) - CW'(rsp_keep);
            drop_q  <= drop_q - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            filled_q <= '0;
        end else if (pcsel_i) begin
            filled_q <= '0;
        end else begin
            if (req_fire) begin
                pc_q[alloc_q]     <= fetch_pc_q;
                filled_q[alloc_q] <= 1'b0;
            end
            if (rsp_keep) begin
                inst_q[fill_q]   <= rsp_data_i;
                filled_q[fill_q] <= 1'b1;
            end
            if (inst_fire) begin
                filled_q[head_q] <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
        rsp_valid_i |-> (drop_q != '0 || pend_q != '0));
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: a driver queues expected {pc, inst} pairs per fetch stream,
// a latency-configurable memory model answers requests, and a monitor checks every consume.
module tb_ifu_prefetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pcsel = 1'b0;
    logic [31:0] dnpc = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;

    ifu_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .pcsel_i      (pcsel),
        .dnpc_i       (dnpc),
        .req_valid_o  (req_valid),
        .req_ready_i  (req_ready),
        .req_addr_o   (req_addr),
        .rsp_valid_i  (rsp_valid),
        .rsp_data_i   (rsp_data),
        .inst_valid_o (inst_valid),
        .inst_ready_i (inst_ready),
        .inst_o       (inst),
        .pc_o         (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          epoch;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t  sb[$];
    mreq_t mq[$];
    int    drv_epoch = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    n_fires = 0;
    int    mem_lat = 1;
    int    mcyc = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{pc: start + 32'(4 * i), epoch: drv_epoch});
        end
    endtask

    task automatic do_reset();
        drv_epoch++;
        rst        = 1'b1;
        pcsel      = 1'b0;
        req_ready  = 1'b0;
        inst_ready = 1'b0;
        repeat (2) cyc1();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) cyc1();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d entries left, required 0", name, sb.size());
            sb.delete();
        end
        inst_ready = 1'b0;
    endtask

    // Memory: in-order responses, mem_lat cycles after acceptance, data derived from address.
    initial begin
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst) begin
                mq.delete();
                rsp_valid = 1'b0;
            end else begin
                if (mq.size() != 0 && mq[0].due <= mcyc) begin
                    rsp_valid = 1'b1;
                    rsp_data  = inst_of(mq[0].addr);
                    void'(mq.pop_front());
                end else begin
                    rsp_valid = 1'b0;
                end
                if (req_valid && req_ready) begin
                    mq.push_back('{addr: req_addr, due: mcyc + mem_lat});
                    n_fires++;
                end
            end
        end
    end

    // Monitor: checks each consume, then retires expectations of flushed streams.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got pc %h, required no delivery", pc);
                end else begin
                    e = sb.pop_front();
                    chk("mon_pc", pc, e.pc);
                    chk("mon_inst", inst, inst_of(e.pc));
                end
            end
            if (rst || pcsel) begin
                while (sb.size() != 0 && sb[0].epoch < drv_epoch) void'(sb.pop_front());
            end
        end
    end

    initial begin
        int base;
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc, 32'd0);

        // Streaming with 1-cycle memory
        mem_lat = 1;
        push_stream(RST_PC, 8);
        cyc1();
        cyc1();
        rst        = 1'b0;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        #1;
        chk("first_req_valid", 32'(req_valid), 32'd1);
        chk("first_req_addr", req_addr, RST_PC);
        chk("lat_c0", 32'(inst_valid), 32'd0);
        cyc1();
        chk("lat_c1", 32'(inst_valid), 32'd0);
        cyc1();
        chk("lat_c2", 32'(inst_valid), 32'd1);
        chk("lat_c2_pc", pc, RST_PC);
        for (int i = 0; i < 4; i++) begin
            cyc1();
            chk("throughput", 32'(inst_valid), 32'd1);
        end
        wait_drain("stream", 50);

        // Backpressure: queue fills to DEPTH, then drains in order
        do_reset();
        req_ready = 1'b1;
        base = n_fires;
        repeat (10) cyc1();
        chk("bp_reqs", 32'(n_fires - base), 32'd4);
        chk("bp_req_valid", 32'(req_valid), 32'd0);
        chk("bp_head_pc", pc, RST_PC);
        push_stream(RST_PC, 4);
        inst_ready = 1'b1;
        wait_drain("bp", 50);

        // Redirect with two stale fetches in flight on a 3-cycle memory
        do_reset();
        mem_lat   = 3;
        req_ready = 1'b1;
        cyc1();
        cyc1();
        req_ready = 1'b0;
        drv_epoch++;
        push_stream(32'h8000_0100, 4);
        pcsel = 1'b1;
        dnpc  = 32'h8000_0100;
        #1;
        chk("redir_req_low", 32'(req_valid), 32'd0);
        cyc1();
        pcsel      = 1'b0;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        #1;
        chk("redir_req_valid", 32'(req_valid), 32'd1);
        chk("redir_req_addr", req_addr, 32'h8000_0100);
        wait_drain("redir", 100);

        // Redirect coinciding with a response and a consume
        do_reset();
        mem_lat = 1;
        push_stream(RST_PC, 10);
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        repeat (6) cyc1();
        drv_epoch++;
        push_stream(32'h8000_0200, 20);
        pcsel = 1'b1;
        dnpc  = 32'h8000_0200;
        @(negedge clk);
        #1;
        chk("coinc_rsp", 32'(rsp_valid), 32'd1);
        chk("coinc_consume", 32'(inst_valid), 32'd1);
        cyc1();
        pcsel = 1'b0;
        wait_drain("coinc", 200);

        // Asynchronous reset with three entries filled
        do_reset();
        req_ready = 1'b1;
        repeat (3) cyc1();
        req_ready = 1'b0;
        repeat (3) cyc1();
        chk("pre_rst_valid", 32'(inst_valid), 32'd1);
        chk("pre_rst_pc", pc, RST_PC);
        drv_epoch++;
        rst = 1'b1;
        #1;
        chk("async_inst_valid", 32'(inst_valid), 32'd0);
        chk("async_inst", inst, 32'd0);
        chk("async_pc", pc, 32'd0);
        chk("async_req_valid", 32'(req_valid), 32'd0);
        cyc1();
        cyc1();
        push_stream(RST_PC, 3);
        rst = 1'b0;
        #1;
        chk("restart_addr", req_addr, RST_PC);
        chk("restart_valid", 32'(req_valid), 32'd1);
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        wait_drain("restart", 50);

        // Random handshakes over 1000 fetches
        do_reset();
        mem_lat = 2;
        push_stream(RST_PC, 1000);
        for (int i = 0; i < 20000 && sb.size() != 0; i++) begin
            req_ready  = 1'($urandom_range(0, 1));
            inst_ready = (sb.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc1();
        end
        wait_drain("random", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
